uart_reg_ctrl: RTL and testbench

- Byte-level register-access controller between the UART RX/TX byte streams and the R-peak detection datapath inside the core.
- Decodes command bytes {4'b0, addr[2:0], rw}.
- On writes: assembles 11-bit ECG samples from DINL/DINH and issues them to the algorithm.
- On reads: buffers 22-bit R-peak sample numbers in a FIFO and serves them byte-wise through DOUTL/M/H.
- Exposes CR/SR control and status registers.

---
 rtl/uart_reg_ctrl_pkg.sv | 51 +++++
 rtl/uart_reg_ctrl_rpeak_fifo.sv | 81 ++++++++
 rtl/uart_reg_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_reg_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alg_pkg / uart_pkg
//  Description : Shared types for the UART register-access controller.
//                alg_pkg   - R-peak sample-number type used by the algorithm.
//                uart_pkg  - register offsets, SR/CR layouts, FSM state enum.
//  Ports       : none (packages)
//  Revision    : 1.0 - initial release
// ============================================================================

package alg_pkg;
    localparam int CTR_WIDTH = 22;
    typedef logic [CTR_WIDTH-1:0] sample_num;
endpackage : alg_pkg

package uart_pkg;
    // Register offsets: the command byte carries the offset in bits [3:1].
    localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
    localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
    localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
    localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
    localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
    localparam logic [2:0] UART_DOUTM_OFFSET = 3'd5;
    localparam logic [2:0] UART_DOUTH_OFFSET = 3'd6;
    localparam logic [2:0] UART_RSVD_OFFSET  = 3'd7;

    // Status register, MSB first.
    typedef struct packed {
        logic [2:0] rsvd;
        logic       run;
        logic       cmd_err;
        logic       ovf;
        logic       tx_fifo_full;
        logic       tx_fifo_empty;
    } uart_sr_t;

    // Control register, MSB first. flush is a write-only strobe.
    typedef struct packed {
        logic [5:0] rsvd;
        logic       run;
        logic       flush;
    } cr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RRESP = 2'd2
    } ctrl_state_e;
endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_reg_ctrl_rpeak_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rpeak_fifo
//  Description : Synchronous FIFO for R-peak sample numbers. Head is read
//                combinationally; flush empties the FIFO and wins over a
//                push or pop in the same cycle. A push while full is accepted
//                only when a pop frees an entry in the same cycle.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                i_push/i_push_data - write strobe and data
//                i_pop             - remove head (ignored when empty)
//                i_flush           - discard all entries
//                o_head            - current head entry
//                o_full/o_empty    - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================

module rpeak_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16   // power of 2, at least 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_WIDTH = c_PTR_WIDTH + 1;
    localparam logic [c_CNT_WIDTH-1:0] c_FULL_CNT = c_CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [c_PTR_WIDTH-1:0] r_wr_ptr;
    logic [c_PTR_WIDTH-1:0] r_rd_ptr;
    logic [c_CNT_WIDTH-1:0] r_count;
    logic                   w_pop;
    logic                   w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_push = i_push & ~i_flush & (~o_full | w_pop);

    // Storage carries no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule : rpeak_fifo

`default_nettype wire

// File: rtl/uart_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_ctrl
//  Description : Byte-level register-access controller between the UART
//                RX/TX byte streams and the R-peak detection datapath.
//                Command byte {4'b0, addr[2:0], rw}; writes take one data
//                byte, reads answer with one byte through tx_data.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                rx_data, rx_data_valid     - received byte stream
//                tx_data, tx_data_valid     - transmitted byte stream
//                tx_ready                   - UART TX can take a byte
//                sample_out, sample_valid   - assembled ECG sample to algorithm
//                rpeak_in, rpeak_valid      - R-peak sample numbers from algorithm
//                run                        - algorithm enable (CR.run)
//  Revision    : 1.0 - initial release
// ============================================================================

module uart_reg_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 11,
    parameter int CTR_WIDTH      = 22,       // at most 24
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    input  logic [CTR_WIDTH-1:0]  rpeak_in,
    input  logic                  rpeak_valid,
    output logic                  run
);
    localparam int c_TO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_WIDTH-1:0] c_TO_LAST = c_TO_WIDTH'(TIMEOUT_CYCLES - 1);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_nxt;
    logic [2:0]            r_addr;
    logic [c_TO_WIDTH-1:0] r_to_cnt;
    logic                  r_run;
    logic [7:0]            r_dinl;
    logic [2:0]            r_dinh;
    logic                  r_cmd_err;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_sample_out;
    logic                  r_sample_valid;

    logic                  w_cmd_hdr_ok;
    logic                  w_cmd_bad;
    logic                  w_timeout;
    logic                  w_rx_drop;
    logic                  w_wr;
    logic                  w_flush;
    logic                  w_tx_fire;
    logic                  w_sr_rd;
    logic                  w_pop;
    logic                  w_ovf_set;
    logic                  w_cmd_err_set;
    logic [CTR_WIDTH-1:0]  w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [23:0]           w_head_ext;
    uart_sr_t              w_sr;
    cr_t                   w_cr_rd;
    logic [7:0]            w_rd_byte;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_cmd_hdr_ok = (rx_data[7:4] == 4'h0);
    assign w_cmd_bad    = (r_state == ST_IDLE)  & rx_data_valid & ~w_cmd_hdr_ok;
    // Data byte arriving in the expiry cycle still counts as the write.
    assign w_timeout    = (r_state == ST_WDATA) & ~rx_data_valid & (r_to_cnt == c_TO_LAST);
    assign w_rx_drop    = (r_state == ST_RRESP) & rx_data_valid;
    assign w_wr         = (r_state == ST_WDATA) & rx_data_valid;
    // CR bit0 is the flush strobe of the incoming data byte.
    assign w_flush      = w_wr & (r_addr == UART_CR_OFFSET) & rx_data[0];
    assign w_sr_rd      = w_tx_fire & (r_addr == UART_SR_OFFSET);
    assign w_pop        = w_tx_fire & (r_addr == UART_DOUTH_OFFSET) & ~w_fifo_empty;
    // A simultaneous pop makes room, so a push while full is not an overflow.
    assign w_ovf_set    = rpeak_valid & w_fifo_full & ~w_pop & ~w_flush;
    assign w_cmd_err_set = w_cmd_bad | w_timeout | w_rx_drop;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_data_valid && w_cmd_hdr_ok) begin
                    w_state_nxt = rx_data[0] ? ST_WDATA : ST_RRESP;
                end
            end
            ST_WDATA: begin
                if (rx_data_valid || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RRESP: begin
                if (tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The response is combinational on tx_ready so it can
    // leave in the cycle right after the command strobe.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_fire     = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;
        if (r_state == ST_RRESP && tx_ready) begin
            w_tx_fire     = 1'b1;
            tx_data_valid = 1'b1;
            tx_data       = w_rd_byte;
        end
    end

    // ------------------------------------------------------------------
    // Registers and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_to_cnt       <= '0;
            r_run          <= 1'b0;
            r_dinl         <= '0;
            r_dinh         <= '0;
            r_cmd_err      <= 1'b0;
            r_ovf          <= 1'b0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;

            if (r_state == ST_IDLE && rx_data_valid && w_cmd_hdr_ok) begin
                r_addr <= rx_data[3:1];
            end

            // Counter is zero on every entry to WDATA.
            if (r_state == ST_WDATA) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_wr) begin
                case (r_addr)
                    UART_CR_OFFSET:   r_run  <= rx_data[1];
                    UART_DINL_OFFSET: r_dinl <= rx_data;
                    UART_DINH_OFFSET: begin
                        r_dinh <= rx_data[2:0];
                        if (r_run) begin
                            r_sample_valid <= 1'b1;
                            r_sample_out   <= DATA_WIDTH'({rx_data[2:0], r_dinl});
                        end
                    end
                    default: ;
                endcase
            end

            // Sticky flags: a set event in the clearing cycle wins.
            r_cmd_err <= w_cmd_err_set | (r_cmd_err & ~w_sr_rd);
            r_ovf     <= w_ovf_set | (r_ovf & ~w_sr_rd & ~w_flush);
        end
    end

    // ------------------------------------------------------------------
    // R-peak FIFO
    // ------------------------------------------------------------------
    rpeak_fifo #(
        .WIDTH (CTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rpeak_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (rpeak_valid),
        .i_push_data (rpeak_in),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Read mux. DOUT bytes read as zero while the FIFO is empty.
    // ------------------------------------------------------------------
    assign w_head_ext = w_fifo_empty ? 24'h0 : 24'(w_fifo_head);

    always_comb begin
        w_sr               = '0;
        w_sr.run           = r_run;
        w_sr.cmd_err       = r_cmd_err;
        w_sr.ovf           = r_ovf;
        w_sr.tx_fifo_full  = w_fifo_full;
        w_sr.tx_fifo_empty = w_fifo_empty;

        w_cr_rd     = '0;
        w_cr_rd.run = r_run;

        w_rd_byte = 8'h00;
        case (r_addr)
            UART_CR_OFFSET:    w_rd_byte = w_cr_rd;
            UART_SR_OFFSET:    w_rd_byte = w_sr;
            UART_DINL_OFFSET:  w_rd_byte = r_dinl;
            UART_DINH_OFFSET:  w_rd_byte = {5'b0, r_dinh};
            UART_DOUTL_OFFSET: w_rd_byte = w_head_ext[7:0];
            UART_DOUTM_OFFSET: w_rd_byte = w_head_ext[15:8];
            UART_DOUTH_OFFSET: w_rd_byte = w_head_ext[23:16];
            default:           w_rd_byte = 8'h00;
        endcase
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign run          = r_run;
endmodule : uart_reg_ctrl

`default_nettype wire

// File: tb/tb_uart_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_ctrl
//  Description : Self-checking bench for uart_reg_ctrl. Stimulus tasks update
//                a register-level reference model and queue the expected TX
//                bytes / samples; monitors compare whenever the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_reg_ctrl;
    localparam int TIMEOUT = 200;
    localparam int DEPTH   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_ready;
    logic [10:0] sample_out;
    logic        sample_valid;
    logic [21:0] rpeak_in;
    logic        rpeak_valid;
    logic        run;

    always #5 clk = ~clk;

    uart_reg_ctrl #(
        .DATA_WIDTH     (11),
        .CTR_WIDTH      (22),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_ready      (tx_ready),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .rpeak_in      (rpeak_in),
        .rpeak_valid   (rpeak_valid),
        .run           (run)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues
    logic [7:0]  tx_q[$];
    logic [10:0] smp_q[$];

    // Reference model state
    bit          m_run;
    logic [7:0]  m_dinl;
    logic [2:0]  m_dinh;
    bit          m_cmd_err;
    bit          m_ovf;
    logic [21:0] m_fifo[$];

    logic [7:0]  mon_tx_exp;
    logic [10:0] mon_smp_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_dinl = 8'h00; m_dinh = 3'h0;
        m_cmd_err = 0; m_ovf = 0;
        m_fifo.delete();
    endfunction

    // Value the register file returns for a read, plus its side effects.
    function automatic logic [7:0] model_read(input logic [2:0] a);
        logic [7:0]  r;
        logic [23:0] h;
        h = (m_fifo.size() == 0) ? 24'h0 : 24'(m_fifo[0]);
        case (a)
            3'd0: r = {6'b0, m_run, 1'b0};
            3'd1: begin
                r = {3'b0, m_run, m_cmd_err, m_ovf,
                     (m_fifo.size() == DEPTH), (m_fifo.size() == 0)};
                m_cmd_err = 0;
                m_ovf     = 0;
            end
            3'd2: r = m_dinl;
            3'd3: r = {5'b0, m_dinh};
            3'd4: r = h[7:0];
            3'd5: r = h[15:8];
            3'd6: begin
                r = h[23:16];
                if (m_fifo.size() != 0) void'(m_fifo.pop_front());
            end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        step();
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
    endtask

    task automatic do_read(input logic [2:0] a);
        tx_q.push_back(model_read(a));
        send_byte({4'h0, a, 1'b0});
        step();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        send_byte({4'h0, a, 1'b1});
        case (a)
            3'd0: begin
                m_run = d[1];
                if (d[0]) begin
                    m_fifo.delete();
                    m_ovf = 0;
                end
            end
            3'd2: m_dinl = d;
            3'd3: begin
                m_dinh = d[2:0];
                if (m_run) smp_q.push_back({m_dinh, m_dinl});
            end
            default: ;
        endcase
        send_byte(d);
        chk("run_after_write", 32'(run), 32'(m_run));
    endtask

    task automatic push_burst(input int n, input bit fixed, input logic [21:0] v);
        for (int i = 0; i < n; i++) begin
            rpeak_in    = fixed ? v : 22'($urandom);
            rpeak_valid = 1'b1;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(rpeak_in);
            else                       m_ovf = 1;
            step();
        end
        rpeak_valid = 1'b0;
    endtask

    task automatic bad_cmd();
        logic [7:0] b;
        b = {4'($urandom_range(1, 15)), 4'($urandom)};
        send_byte(b);
        m_cmd_err = 1;
    endtask

    task automatic run_random(input int n);
        int unsigned op;
        logic [2:0]  a;
        logic [7:0]  d;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                do_read(3'($urandom));
            end else if (op <= 4) begin
                a = 3'($urandom);
                d = 8'($urandom);
                if (a == 3'd0) d = {6'b0, 1'($urandom), ($urandom_range(0, 3) == 0)};
                do_write(a, d);
            end else if (op <= 6) begin
                push_burst(1, 1'b0, 22'h0);
            end else if (op == 7) begin
                push_burst($urandom_range(2, 20), 1'b0, 22'h0);
            end else if (op == 8) begin
                bad_cmd();
            end else begin
                step();
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tx_data"},       32'(tx_data),       32'h0);
        chk({tag, "_tx_data_valid"}, 32'(tx_data_valid), 32'h0);
        chk({tag, "_sample_out"},    32'(sample_out),    32'h0);
        chk({tag, "_sample_valid"},  32'(sample_valid),  32'h0);
        chk({tag, "_run"},           32'(run),           32'h0);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tx_data_valid === 1'b1) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got byte 0x%02h expected no response", tx_data);
                end else begin
                    mon_tx_exp = tx_q.pop_front();
                    if (tx_data !== mon_tx_exp) begin
                        errors++;
                        $display("FAIL tx_byte: got 0x%02h expected 0x%02h", tx_data, mon_tx_exp);
                    end
                end
            end
            if (sample_valid === 1'b1) begin
                checks++;
                if (smp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sample_unexpected: got 0x%03h expected no pulse", sample_out);
                end else begin
                    mon_smp_exp = smp_q.pop_front();
                    if (sample_out !== mon_smp_exp) begin
                        errors++;
                        $display("FAIL sample_out: got 0x%03h expected 0x%03h", sample_out, mon_smp_exp);
                    end
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        tx_ready      = 1'b1;
        rpeak_in      = 22'h0;
        rpeak_valid   = 1'b0;
        model_reset();
        repeat (3) step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // SR after reset: FIFO empty only
        do_read(3'd1);

        // Sample assembly with run=1, then with run=0 (no pulse)
        do_write(3'd0, 8'h02);
        do_write(3'd2, 8'hF3);
        do_write(3'd3, 8'h03);
        do_write(3'd0, 8'h00);
        do_write(3'd3, 8'h03);
        do_write(3'd2, 8'h11);   // DINL alone never issues a sample

        // Single R-peak readout
        do_write(3'd0, 8'h02);
        push_burst(1, 1'b1, 22'h2A5B3C);
        do_read(3'd4);
        do_read(3'd5);
        do_read(3'd6);
        do_read(3'd1);
        do_read(3'd6);           // empty FIFO reads zero

        // Overflow, sticky clear, flush
        push_burst(DEPTH + 1, 1'b0, 22'h0);
        do_read(3'd1);
        do_read(3'd1);
        do_write(3'd0, 8'h03);
        do_read(3'd1);

        // Malformed command
        send_byte(8'hF1);
        m_cmd_err = 1;
        do_read(3'd2);
        do_read(3'd1);

        // Write command with no data byte times out
        send_byte(8'h05);
        repeat (TIMEOUT + 5) step();
        m_cmd_err = 1;
        do_read(3'd2);
        do_read(3'd1);

        // Response held off by tx_ready; an rx byte during the wait is dropped
        tx_ready = 1'b0;
        tx_q.push_back(model_read(3'd2));
        send_byte(8'h04);
        repeat (20) step();
        send_byte(8'h04);
        m_cmd_err = 1;
        repeat (28) step();
        tx_ready = 1'b1;
        step();
        step();
        do_read(3'd1);

        // Randomized traffic
        run_random(400);
        step();

        // Reset in the middle of a write command
        do_write(3'd0, 8'h02);
        do_write(3'd2, 8'hA5);
        send_byte(8'h05);
        rst_n = 1'b0;
        #2;
        chk_idle_outputs("midreset");
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        do_read(3'd2);
        do_read(3'd1);

        repeat (5) step();
        chk("tx_queue_drained",     32'(tx_q.size()),  32'h0);
        chk("sample_queue_drained", 32'(smp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_uart_reg_ctrl

`default_nettype wire
